// File: rtl/spi_responder_pkg.sv
// -----------------------------------------------------------------------------
// spi_responder_pkg
// Shared definitions for the SPI mode-0 responder:
//   - DATA_WIDTH_DEF : default SPI word width in bits
//   - IDLE_FILL_DEF  : default MISO word sent when no TX word is queued
//   - SYNC_STAGES    : depth of the input synchronizers
//   - state_t        : responder FSM states (IDLE, LOAD, SHIFT)
// -----------------------------------------------------------------------------
package spi_responder_pkg;

    localparam int         DATA_WIDTH_DEF = 8;
    localparam logic [7:0] IDLE_FILL_DEF  = 8'h00;
    localparam int         SYNC_STAGES    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_sync_2ff.sv
// -----------------------------------------------------------------------------
// spi_sync_2ff
// Flip-flop synchronizer bringing one asynchronous SPI pin into the clk
// domain. The reset value is per instance so that idle-high pins (slave
// select) do not produce a false edge when reset is released.
// Ports:
//   clk      in  system clock
//   reset    in  asynchronous active-high reset
//   i_async  in  asynchronous input pin
//   o_sync   out synchronized copy of i_async
// -----------------------------------------------------------------------------
module spi_sync_2ff
    import spi_responder_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_stages;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stages <= {SYNC_STAGES{RST_VAL}};
        end else begin
            r_stages <= {r_stages[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_stages[SYNC_STAGES-1];

endmodule

// File: rtl/spi_pmod_responder.sv
// -----------------------------------------------------------------------------
// spi_pmod_responder
// SPI mode-0 (CPOL=0, CPHA=0), MSB-first slave. All SPI pins are
// oversampled in the clk domain (clk must be >= 8x SCLK). A one-word TX
// holding register feeds the TX shifter; received words are presented on
// rx_data with a one-cycle rx_valid strobe (no backpressure).
// Ports:
//   clk, reset             system clock, asynchronous active-high reset
//   spi_sclk/ss_n/mosi     asynchronous SPI inputs from the master
//   spi_miso, spi_miso_oe  slave data out and its output enable
//   tx_data/valid/ready    TX word handshake into the holding register
//   rx_data, rx_valid      last received word and its new-data strobe
//   tx_underrun            strobe: a word slot started with nothing queued
//   rx_abort               strobe: slave select rose in the middle of a word
// -----------------------------------------------------------------------------
module spi_pmod_responder
    import spi_responder_pkg::*;
#(
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] IDLE_FILL  = DATA_WIDTH'(IDLE_FILL_DEF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  spi_sclk,
    input  logic                  spi_ss_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  rx_abort
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    // Synchronized pins and edge detection
    logic w_sclk_s, w_ss_n_s, w_mosi_s;
    logic r_sclk_d, r_ss_n_d;
    logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;

    spi_sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .reset   (reset),
        .i_async (spi_sclk),
        .o_sync  (w_sclk_s)
    );

    spi_sync_2ff #(.RST_VAL(1'b1)) u_sync_ss_n (
        .clk     (clk),
        .reset   (reset),
        .i_async (spi_ss_n),
        .o_sync  (w_ss_n_s)
    );

    spi_sync_2ff #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .reset   (reset),
        .i_async (spi_mosi),
        .o_sync  (w_mosi_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_d <= 1'b0;
            r_ss_n_d <= 1'b1;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_ss_n_d <= w_ss_n_s;
        end
    end

    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_ss_fall   = ~w_ss_n_s & r_ss_n_d;
    assign w_ss_rise   = w_ss_n_s & ~r_ss_n_d;

    // Datapath state
    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_full;
    logic                  r_tx_ready;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_tx_underrun;
    logic                  r_rx_abort;
    // A next-word MSB is presented on the trailing SCLK fall of a word, but
    // the slot is only consumed once the master actually clocks the next
    // word. r_pending marks such a provisional load; r_pend_hold records
    // whether it came from the holding register or from IDLE_FILL.
    logic                  r_pending;
    logic                  r_pend_hold;

    // FSM decode controls
    logic w_load_first;   // first word of a select: load in LOAD
    logic w_peek;         // provisional next-word load at trailing fall
    logic w_commit;       // first rise of a following word: commit the slot
    logic w_shift;        // ordinary MISO shift on SCLK fall
    logic w_sample;       // MOSI sample on SCLK rise
    logic w_end;          // slave select released
    logic w_abort;        // released mid-word

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_first = 1'b0;
        w_peek       = 1'b0;
        w_commit     = 1'b0;
        w_shift      = 1'b0;
        w_sample     = 1'b0;
        w_end        = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // SCLK activity is ignored until the slave is selected
                if (w_ss_fall) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load_first = 1'b1;
                w_state_nxt  = w_ss_rise ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_ss_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_end       = 1'b1;
                    w_abort     = (r_bit_cnt != '0);
                end else begin
                    if (w_sclk_rise) begin
                        w_sample = 1'b1;
                        w_commit = r_pending && (r_bit_cnt == '0);
                    end
                    if (w_sclk_fall) begin
                        // a fall with the counter at 0 follows a completed word
                        if (r_bit_cnt == '0) begin
                            w_peek = 1'b1;
                        end else begin
                            w_shift = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Holding register handshake. Accept only happens while empty, so it
    // never collides with a pop; a word offered during a load cycle lands
    // in the holding register after the held word has been taken.
    logic                  w_accept;
    logic                  w_hold_pop;
    logic                  w_underrun;
    logic                  w_hold_full_nxt;
    logic [DATA_WIDTH-1:0] w_tx_word;
    logic                  w_word_done;

    assign w_accept        = tx_valid && r_tx_ready;
    assign w_hold_pop      = (w_load_first && r_hold_full) || (w_commit && r_pend_hold);
    assign w_underrun      = (w_load_first && !r_hold_full) || (w_commit && !r_pend_hold);
    assign w_hold_full_nxt = (r_hold_full && !w_hold_pop) || w_accept;
    assign w_tx_word       = r_hold_full ? r_hold : IDLE_FILL;
    assign w_word_done     = w_sample && (r_bit_cnt == LAST_BIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_tx_ready    <= 1'b0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_bit_cnt     <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_rx_abort    <= 1'b0;
            r_pending     <= 1'b0;
            r_pend_hold   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold <= tx_data;
            end
            r_hold_full <= w_hold_full_nxt;
            // registered so that tx_ready stays low until the first edge after reset
            r_tx_ready  <= ~w_hold_full_nxt;

            if (w_load_first || w_peek) begin
                r_tx_shift <= w_tx_word;
            end else if (w_shift) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end

            if (w_peek) begin
                r_pending   <= 1'b1;
                r_pend_hold <= r_hold_full;
            end else if (w_commit || w_end) begin
                r_pending   <= 1'b0;
                r_pend_hold <= 1'b0;
            end

            if (w_load_first || w_end) begin
                r_bit_cnt  <= '0;
                r_rx_shift <= '0;
            end else if (w_sample) begin
                r_bit_cnt  <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + CNT_W'(1);
                r_rx_shift <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};
            end

            if (w_word_done) begin
                r_rx_data <= {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};
            end
            r_rx_valid    <= w_word_done;
            r_tx_underrun <= w_underrun;
            r_rx_abort    <= w_abort;
        end
    end

    assign spi_miso_oe = (r_state != ST_IDLE);
    assign spi_miso    = (r_state != ST_IDLE) && r_tx_shift[DATA_WIDTH-1];
    assign tx_ready    = r_tx_ready;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_tx_underrun;
    assign rx_abort    = r_rx_abort;

endmodule

// File: doc/spi_pmod_responder.md
SPI_PMOD_RESPONDER -- requirements
Module: spi_pmod_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the number of bits per SPI word.
REQ-002 SHALL have parameter IDLE_FILL, default 8'h00, meaning the MISO word sent when no TX word is queued.
REQ-003 SHALL use one clock and an asynchronous active-high reset.
REQ-004 Port: clk  in  1  system clock (50 MHz), sole clock domain.
REQ-005 Port: reset  in  1  asynchronous active-high reset.
REQ-006 Port: spi_sclk  in  1  SPI clock from the external master, asynchronous.
REQ-007 Port: spi_ss_n  in  1  active-low slave select, asynchronous.
REQ-008 Port: spi_mosi  in  1  master-out data, asynchronous.
REQ-009 Port: spi_miso  out  1  slave-out data.
REQ-010 Port: spi_miso_oe  out  1  MISO output enable; the top level drives Z when it is 0.
REQ-011 Port: tx_data  in  DATA_WIDTH  next word to transmit.
REQ-012 Port: tx_valid / tx_ready  in / out  1  TX valid/ready handshake.
REQ-013 Port: rx_data  out  DATA_WIDTH  last received word.
REQ-014 Port: rx_valid  out  1  one-cycle strobe that marks rx_data as new.
REQ-015 Port: tx_underrun, rx_abort  out  1  one-cycle status strobes.

Function
REQ-016 The block SHALL support SPI mode 0 only, MSB first: MOSI sampled on SCLK rising edge, MISO changed on SCLK falling edge.
REQ-017 spi_sclk, spi_ss_n and spi_mosi SHALL each pass through a 2-FF synchronizer; edges SHALL be detected on the synchronized signals.
REQ-018 clk SHALL be at least 8x the SCLK frequency; this is a documented constraint and is not checked in RTL.
REQ-019 FSM states SHALL be IDLE, LOAD and SHIFT.
REQ-020 IDLE -> LOAD on a synchronized ss_n falling edge; LOAD -> SHIFT after one cycle; SHIFT -> IDLE on a ss_n rising edge.
REQ-021 In LOAD and at every word boundary in SHIFT:
  - the TX shift register SHALL load the holding register if it is full; otherwise it SHALL load IDLE_FILL and pulse tx_underrun.
  - spi_miso SHALL present the MSB.
REQ-022 The holding register is one word deep; tx_ready = holding register empty; a word is accepted when tx_valid && tx_ready.
REQ-023 If accept and load occur in the same cycle, the loaded word SHALL be the one already held, and the new word SHALL enter the holding register.
REQ-024 Bit counter SHALL count 0..DATA_WIDTH-1 on sampled rising edges and wrap to 0.
REQ-025 On wrap, rx_data SHALL update and rx_valid SHALL pulse for 1 cycle, 1 clk after the last-bit sample.
REQ-026 There is no RX backpressure; an unread rx_data SHALL be overwritten.
REQ-027 Back-to-back words with ss_n held low SHALL be supported with no gap cycles required.
REQ-028 ss_n rising edge mid-word (counter != 0):
  - the partial word SHALL be discarded with no rx_valid, and rx_abort SHALL pulse.
  - the consumed TX word SHALL NOT be re-queued.
REQ-029 spi_miso_oe SHALL be 1 in LOAD and SHIFT and 0 in IDLE; spi_miso SHALL be 0 in IDLE.
REQ-030 SCLK edges while in IDLE SHALL be ignored.

Reset
REQ-031 On reset assertion:
  - FSM -> IDLE; counter, shift registers, holding register and rx_data -> 0.
  - Synchronizers: ss_n stages -> 1, sclk and mosi stages -> 0.
REQ-032 All outputs SHALL be 0 during reset except tx_ready; tx_ready SHALL be 1 after the first clk edge following reset release.
REQ-033 Reset mid-transfer SHALL abort silently, with no rx_valid and no rx_abort.

Structure
REQ-034 Package spi_responder_pkg SHALL hold the FSM state enum, DATA_WIDTH default, IDLE_FILL default and SYNC_STAGES = 2.
REQ-035 The sole sub-module SHALL be spi_sync_2ff, instantiated three times with a per-instance reset value parameter.

Verification
REQ-036 Master sends 8'hA5 while tx 8'h3C is queued -> rx_data = 8'hA5 with one rx_valid; the master reads 8'h3C; tx_ready returns to 1 after LOAD.
REQ-037 Three back-to-back words 8'h01, 8'h80, 8'hFF with ss_n held low and tx 8'h11 queued only -> three rx_valid strobes in order; MISO = 8'h11, 8'h00, 8'h00; tx_underrun pulses twice.
REQ-038 ss_n deasserted after 5 bits -> rx_abort pulses once, no rx_valid, spi_miso_oe = 0; the next full word 8'h5A is received correctly.
REQ-039 tx_valid arrives in the same cycle as a word-boundary load -> the held word is sent first and the new word is sent next; no word is lost or duplicated.
REQ-040 reset asserted at bit 4 -> all outputs go to their reset values immediately with no strobes; after release, a transfer of 8'hC3 succeeds at SCLK = clk/8.
